// File: rtl/xsim_msg_source_arb_if.sv
// Channel-side and emit-side signals of the multi-channel message source arbiter.
// The master drives beats into the channels; the slave (the arbiter) emits the serialised stream.
interface xsim_msg_source_arb_if #(
   parameter int NUM_CHAN   = 4,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_CHAN-1:0]            in_valid;
   logic [NUM_CHAN-1:0]            in_ready;
   logic [NUM_CHAN*DATA_WIDTH-1:0] in_beat;
   logic [NUM_CHAN*32-1:0]         in_portal;
   logic                           en_beat;
   logic [31:0]                    portal;
   logic [DATA_WIDTH-1:0]          beat;
   logic [NUM_CHAN-1:0]            drop_err;

   modport master (
      output in_valid, in_beat, in_portal,
      input  in_ready, en_beat, portal, beat, drop_err
   );

   modport slave (
      input  in_valid, in_beat, in_portal,
      output in_ready, en_beat, portal, beat, drop_err
   );
endinterface

// File: rtl/xsim_msg_source_arb.sv
// Buffers per-channel beat streams and round-robin arbitrates whole messages onto
// one registered beat stream; the header's low 16 bits give the message length in beats.
module xsim_msg_source_arb #(
   parameter int NUM_CHAN   = 4,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   xsim_msg_source_arb_if.slave  bus
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;
   localparam int CH_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

   typedef enum logic {IDLE, BURST} state_t;

   logic [DATA_WIDTH-1:0] mem    [NUM_CHAN][DEPTH];
   logic [AW-1:0]         wr_ptr [NUM_CHAN];
   logic [AW-1:0]         rd_ptr [NUM_CHAN];
   logic [CNT_W-1:0]      count  [NUM_CHAN];
   logic [DATA_WIDTH-1:0] head   [NUM_CHAN];
   logic [DATA_WIDTH-1:0] chan_beat   [NUM_CHAN];
   logic [31:0]           chan_portal [NUM_CHAN];
   logic [NUM_CHAN-1:0]   ready;
   logic [NUM_CHAN-1:0]   push;
   logic [NUM_CHAN-1:0]   pop_vec;

   state_t          state, state_n;
   logic [CH_W-1:0] grant, grant_n;
   logic [CH_W-1:0] rr_ptr, rr_n;
   logic [15:0]     remaining, rem_n;
   logic            pop;
   logic [CH_W-1:0] pop_ch;
   logic            found;
   int              idx;
   logic [15:0]     len;

   always_comb begin
      for (int i = 0; i < NUM_CHAN; i++) begin
         ready[i]       = (count[i] != CNT_W'(DEPTH));
         push[i]        = bus.in_valid[i] & ready[i];
         head[i]        = mem[i][rd_ptr[i]];
         chan_beat[i]   = bus.in_beat[i*DATA_WIDTH +: DATA_WIDTH];
         chan_portal[i] = bus.in_portal[i*32 +: 32];
      end
   end

   assign bus.in_ready = ready;

   // NOTE: every variable gets a default before the case so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_n = state;
      grant_n = grant;
      rr_n    = rr_ptr;
      rem_n   = remaining;
      pop     = 1'b0;
      pop_ch  = grant;
      pop_vec = '0;
      found   = 1'b0;
      idx     = 0;
      len     = '0;
      case (state)
         IDLE: begin
            for (int k = 1; k <= NUM_CHAN; k++) begin
               idx = int'(rr_ptr) + k;
               if (idx >= NUM_CHAN) idx = idx - NUM_CHAN;
               if (!found && count[idx] != '0) begin
                  found  = 1'b1;
                  pop_ch = CH_W'(idx);
               end
            end
            if (found) begin
               pop     = 1'b1;
               rr_n    = pop_ch;
               grant_n = pop_ch;
               len     = head[pop_ch][15:0];
               if (len > 16'd1) begin
                  state_n = BURST;
                  rem_n   = len - 16'd1;
               end
            end
         end
         BURST: begin
            if (count[grant] != '0) begin
               pop   = 1'b1;
               rem_n = remaining - 16'd1;
               if (remaining == 16'd1) state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      if (pop) pop_vec[pop_ch] = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         grant     <= '0;
         rr_ptr    <= CH_W'(NUM_CHAN - 1);
         remaining <= '0;
      end else begin
         state     <= state_n;
         grant     <= grant_n;
         rr_ptr    <= rr_n;
         remaining <= rem_n;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            if (push[i])    wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (pop_vec[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
            case ({push[i], pop_vec[i]})
               2'b10:   count[i] <= count[i] + 1'b1;
               2'b01:   count[i] <= count[i] - 1'b1;
               default: count[i] <= count[i];
            endcase
         end
      end
   end

   // NOTE: storage is left unreset; pointers and counts define validity, so stale words are never read.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= chan_beat[i];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         bus.en_beat  <= 1'b0;
         bus.portal   <= '0;
         bus.beat     <= '0;
         bus.drop_err <= '0;
      end else begin
         bus.en_beat  <= pop;
         bus.drop_err <= bus.drop_err | (bus.in_valid & ~ready);
         if (pop) begin
            bus.beat   <= head[pop_ch];
            bus.portal <= chan_portal[pop_ch];
         end
      end
   end
endmodule

// File: doc/xsim_msg_source_arb.md
Name: xsim_msg_source_arb

Overview:
- Multi-channel, message-aware successor to the single-portal simulation message source.
- Buffers beat streams from NUM_CHAN portals in per-channel FIFOs.
- Round-robin arbitrates between whole messages and drives one serialised beat stream (en_beat/portal/beat) into the DPI message-source shim.
- Never interleaves beats of different messages; each message is framed by the length field of its header beat.

Parameters:
- NUM_CHAN, 4, number of input channels (1..16).
- DATA_WIDTH, 32, beat width in bits (at least 16).
- DEPTH, 8, per-channel FIFO depth in beats; power of 2, at least 2.

Ports:
- CLK  input  1  sole clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_CHAN  per-channel beat valid.
- in_ready  output  NUM_CHAN  per-channel FIFO not full.
- in_beat  input  NUM_CHAN*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_portal  input  NUM_CHAN*32  static portal number per channel, same slicing at 32 bits.
- en_beat  output  1  registered; high for exactly the cycles a beat is emitted.
- portal  output  32  registered portal number of the emitted beat.
- beat  output  DATA_WIDTH  registered emitted beat.
- drop_err  output  NUM_CHAN  sticky: channel saw in_valid while in_ready was low.

Behaviour:
- Reset, asynchronous, RST=1:
  - FIFOs empty; in_ready all 1; en_beat=0; portal=0; beat=0; drop_err=0.
  - State IDLE; rr_ptr=NUM_CHAN-1, so channel 0 wins first.
  - Reset mid-message discards buffered and partially emitted data; no completion is emitted.
- Push:
  - A beat is accepted on an edge where in_valid[i] & in_ready[i].
  - in_ready[i] = (count[i] != DEPTH), taken from registered count; pop in the same cycle does not raise it.
  - in_valid[i] & ~in_ready[i] sets drop_err[i]; the beat is discarded.
- Header format: first beat of a message; bits [15:0] = total beats including header. Length 0 is treated as 1.
- State machine:
  - IDLE:
    - Candidates are channels with non-empty FIFOs.
    - Search starts at rr_ptr+1 mod NUM_CHAN; the first non-empty channel wins.
    - The winner's header is popped this cycle; rr_ptr <= winner.
    - If length<=1, stay IDLE; else go to BURST with remaining = length-1 (16-bit).
    - No candidates: nothing popped.
  - BURST:
    - Only the granted channel is popped; one beat per cycle while its FIFO is non-empty.
    - remaining decrements on each pop.
    - The pop taking remaining to 0 returns to IDLE.
    - Granted FIFO empty: no pop, en_beat=0 next cycle, grant held (stall). Other channels are never served mid-message.
- Output:
  - Each pop registers en_beat<=1, beat<=popped data, portal<=in_portal of the popped channel at that edge.
  - Edges without a pop give en_beat<=0; portal and beat hold their last values.
- Latency:
  - A beat pushed at edge k into an empty channel with the arbiter idle is popped at edge k+1.
  - It is visible on en_beat/beat after edge k+1.
- Throughput:
  - Up to one beat per cycle.
  - Back-to-back messages, same or different channels, have zero bubble cycles: the IDLE decision follows the last BURST pop directly.
- Simultaneous push and pop on the same FIFO in one cycle: count unchanged; both take effect.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH, clog2(DEPTH)+1 bits.

Test Plan:
- Single beat: channel 0, in_portal=5, header 0x0001_0001 pushed at edge k. Required: en_beat=1, portal=5, beat=0x00010001 after edge k+1; en_beat=0 after edge k+2.
- Multi-beat framing:
  - Stimulus: ch1 pushes header length=3 + 2 payload beats; ch2 pushes header length=2 + 1 payload beat, all pushed in the same cycles.
  - Required: five consecutive en_beat cycles in the order ch1 hdr, p0, p1, ch2 hdr, p0; no interleave.
- Round-robin fairness:
  - Stimulus: all 4 channels continuously supply length=1 messages.
  - Required: grant order 0,1,2,3,0,1... after reset; each channel gets exactly 25 of 100 emitted beats.
- Mid-message stall:
  - Stimulus: ch0 header length=4; payload beats 1 and 2 arrive 3 cycles late; ch3 has data pending.
  - Required: en_beat=0 during the gap; no ch3 beat appears before ch0's 4th beat.
- Full/overflow:
  - Stimulus: DEPTH=8, stall the arbiter by holding ch0 mid-message and empty. Push 8 beats into ch1, then a 9th with in_valid=1.
  - Required: in_ready[1]=0 after the 8th push; drop_err[1]=1; the 9th beat is never emitted.
- Async reset mid-burst:
  - Stimulus: assert RST between edges during a length=6 message.
  - Required: en_beat=0 immediately; drop_err=0; in_ready all 1. After release, the next pushed ch0 message emits first.
